// File: rtl/cpu_mem.sv
// Single-port synchronous SRAM for the CPU data memory: inputs captured on the
// rising edge, writes commit at that edge, read data launches on the falling edge.
module cpu_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk0,
    input  logic                  i_resetn,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  csb_p0;
    logic                  web_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;

    // Stage p0: rising-edge capture; reset parks the port in the idle state
    always_ff @(posedge clk0 or negedge i_resetn) begin
        if (!i_resetn) begin
            csb_p0 <= 1'b1;
            web_p0 <= 1'b1;
        end else begin
            csb_p0 <= csb0;
            web_p0 <= web0;
        end
    end

    always_ff @(posedge clk0) begin
        addr_p0 <= addr0;
    end

    // Array is never cleared; writes are held off while reset is asserted
    always_ff @(posedge clk0) begin
        if (i_resetn && !csb0 && !web0) begin
            mem[addr0] <= din0;
        end
    end

    // Stage p1: falling-edge read launch, one half-cycle after capture
    always_ff @(negedge clk0 or negedge i_resetn) begin
        if (!i_resetn) begin
            dout0 <= '0;
        end else if (!csb_p0 && web_p0) begin
            dout0 <= mem[addr_p0];
        end
    end

endmodule

// File: tb/tb_cpu_mem.sv
// Scoreboard bench for cpu_mem: the driver queues expected read data, the monitor
// pops it after each captured read and otherwise checks that dout0 holds.
module tb_cpu_mem;

    logic       clk0;
    logic       i_resetn;
    logic       csb0;
    logic       web0;
    logic [7:0] addr0;
    logic [7:0] din0;
    logic [7:0] dout0;

    cpu_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk0     (clk0),
        .i_resetn (i_resetn),
        .csb0     (csb0),
        .web0     (web0),
        .addr0    (addr0),
        .din0     (din0),
        .dout0    (dout0)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) ^ 8'h5A);
    endfunction

    task automatic go_idle();
        csb0 = 1'b1;
        web0 = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d;
        @(posedge clk0); #1;
        go_idle();
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a;
        @(posedge clk0); #1;
        go_idle();
    endtask

    // Monitor: decides read/no-read from the stimulus seen at each rising edge
    initial begin : monitor
        logic       rd_cap;
        logic       have_last;
        logic [7:0] last_exp;
        logic [7:0] e;
        have_last = 1'b0;
        last_exp  = 8'h00;
        forever begin
            @(posedge clk0);
            rd_cap = i_resetn && !csb0 && web0;
            if (!i_resetn) begin
                last_exp  = 8'h00;
                have_last = 1'b1;
            end
            @(negedge clk0); #1;
            if (!i_resetn) begin
                last_exp  = 8'h00;
                have_last = 1'b1;
                check("reset_dout", dout0, 8'h00);
            end else if (rd_cap) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL read_unexpected: got %h, expected no read data at %0t", dout0, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("read_data", dout0, e);
                    last_exp  = e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                check("dout_hold", dout0, last_exp);
            end
        end
    end

    initial begin : driver
        i_resetn = 1'b0;
        csb0 = 1'b1; web0 = 1'b1; addr0 = 8'h00; din0 = 8'h00;
        repeat (2) @(posedge clk0);
        #1 i_resetn = 1'b1;

        // Fill then sequential read-back, including back-to-back transitions
        for (int i = 0; i < 256; i++) wr(8'(i), pat(i));
        for (int i = 0; i < 256; i++) rd(8'(i), pat(i));

        // Read-after-write on consecutive cycles
        wr(8'h10, 8'hA5);
        rd(8'h10, 8'hA5);

        // Deselect hold: toggling inputs with csb0 high must not write or read
        wr(8'h20, 8'h3C);
        rd(8'h20, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            csb0 = 1'b1; web0 = 1'(i); addr0 = (i % 2 == 0) ? 8'h20 : 8'(i); din0 = 8'hFF - 8'(i);
            @(posedge clk0); #1;
        end
        go_idle();
        rd(8'h20, 8'h3C);

        // Write cycle leaves dout0 untouched
        wr(8'h01, 8'h11);
        rd(8'h01, 8'h11);
        wr(8'h02, 8'h77);
        rd(8'h02, 8'h77);

        // Boundary addresses
        wr(8'h00, 8'h5A);
        wr(8'hFF, 8'hC3);
        rd(8'h00, 8'h5A);
        rd(8'hFF, 8'hC3);

        // Asynchronous reset after the 0xC3 read has landed
        @(negedge clk0); #2;
        i_resetn = 1'b0;
        #1 check("async_reset_immediate", dout0, 8'h00);
        @(posedge clk0); #1;
        i_resetn = 1'b1;
        rd(8'hFF, 8'hC3);
        rd(8'h00, 8'h5A);

        repeat (3) @(posedge clk0);
        #1;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
